// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and road identifiers for the intersection phase scheduler.
package traffic_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_CLR_NS = 3'd0;
    localparam phase_t PH_NS_GRN = 3'd1;
    localparam phase_t PH_NS_YEL = 3'd2;
    localparam phase_t PH_CLR_EW = 3'd3;
    localparam phase_t PH_EW_GRN = 3'd4;
    localparam phase_t PH_EW_YEL = 3'd5;
    localparam phase_t PH_WALK   = 3'd6;

    // Lamp triples are ordered {red, yellow, green}
    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    localparam logic ROAD_NS = 1'b0;
    localparam logic ROAD_EW = 1'b1;

    function automatic lamp_t road_lamp(input phase_t ph, input phase_t grn, input phase_t yel);
        if (ph == grn) begin
            return LAMP_GREEN;
        end else if (ph == yel) begin
            return LAMP_YELLOW;
        end
        return LAMP_RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: clears on phase change, counts ticks, saturates at limit-1.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] last;
    logic             at_last;

    assign last    = limit - {{(CNT_W-1){1'b0}}, 1'b1};
    assign at_last = (count_q == last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick && !at_last) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;
    assign done  = tick && at_last;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road NS/EW intersection sequencer with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase is built only when PED_WALK_EN is defined.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_RED_CLR   = 2,
    parameter int unsigned T_YELLOW    = 10,
    parameter int unsigned T_MIN_GREEN = 15,
    parameter int unsigned T_MAX_GREEN = 60,
    parameter int unsigned T_WALK      = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);

    phase_t           phase_q, phase_d;
    logic             ns_pend_q, ns_pend_d;
    logic             ew_pend_q, ew_pend_d;
    logic             ped_go;
    logic             next_road;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             ns_exit, ew_exit;
    logic             phase_chg;

    always_comb begin
        limit = CNT_W'(T_RED_CLR);
        case (phase_q)
            PH_NS_GRN, PH_EW_GRN: limit = CNT_W'(T_MAX_GREEN);
            PH_NS_YEL, PH_EW_YEL: limit = CNT_W'(T_YELLOW);
            PH_WALK:              limit = CNT_W'(T_WALK);
            default:              limit = CNT_W'(T_RED_CLR);
        endcase
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (phase_chg),
        .tick   (tick),
        .limit  (limit),
        .count  (count),
        .done   (done)
    );

    // In green the timer limit is T_MAX_GREEN, so done doubles as the max-out strobe
    assign ns_exit = ew_pend_q && ((tick && count >= MIN_LAST && !ns_req) || done);
    assign ew_exit = ns_pend_q && ((tick && count >= MIN_LAST && !ew_req) || done);

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_CLR_NS: if (done)    phase_d = ped_go ? PH_WALK : PH_NS_GRN;
            PH_NS_GRN: if (ns_exit) phase_d = PH_NS_YEL;
            PH_NS_YEL: if (done)    phase_d = PH_CLR_EW;
            PH_CLR_EW: if (done)    phase_d = ped_go ? PH_WALK : PH_EW_GRN;
            PH_EW_GRN: if (ew_exit) phase_d = PH_EW_YEL;
            PH_EW_YEL: if (done)    phase_d = PH_CLR_NS;
            PH_WALK:   if (done)    phase_d = (next_road == ROAD_NS) ? PH_NS_GRN : PH_EW_GRN;
            default:                phase_d = PH_CLR_NS;
        endcase
    end

    assign phase_chg = (phase_d != phase_q);

    // Entry into the road's own green clears its flag even if the sensor is still active
    always_comb begin
        ns_pend_d = ns_pend_q;
        if (phase_d == PH_NS_GRN && phase_q != PH_NS_GRN) begin
            ns_pend_d = 1'b0;
        end else if (ns_req && phase_q != PH_NS_GRN) begin
            ns_pend_d = 1'b1;
        end
        ew_pend_d = ew_pend_q;
        if (phase_d == PH_EW_GRN && phase_q != PH_EW_GRN) begin
            ew_pend_d = 1'b0;
        end else if (ew_req && phase_q != PH_EW_GRN) begin
            ew_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_CLR_NS;
            ns_pend_q <= 1'b0;
            ew_pend_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            ns_pend_q <= ns_pend_d;
            ew_pend_q <= ew_pend_d;
        end
    end

`ifdef PED_WALK_EN
    logic ped_pend_q, ped_pend_d;
    logic next_road_q, next_road_d;

    always_comb begin
        ped_pend_d = ped_pend_q;
        if (phase_d == PH_WALK && phase_q != PH_WALK) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && phase_q != PH_WALK) begin
            ped_pend_d = 1'b1;
        end
        next_road_d = next_road_q;
        if (phase_d == PH_WALK && phase_q != PH_WALK) begin
            next_road_d = (phase_q == PH_CLR_EW) ? ROAD_EW : ROAD_NS;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend_q  <= 1'b0;
            next_road_q <= ROAD_NS;
        end else begin
            ped_pend_q  <= ped_pend_d;
            next_road_q <= next_road_d;
        end
    end

    assign ped_go    = ped_pend_q;
    assign next_road = next_road_q;
    assign walk      = (phase_q == PH_WALK);
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_go         = 1'b0;
    assign next_road      = ROAD_NS;
    assign walk           = 1'b0;
`endif

    assign {ns_red, ns_yellow, ns_green} = road_lamp(phase_q, PH_NS_GRN, PH_NS_YEL);
    assign {ew_red, ew_yellow, ew_green} = road_lamp(phase_q, PH_EW_GRN, PH_EW_YEL);
    assign phase = phase_q;

endmodule
